// File: rtl/load_store_unit_if.sv
// load_store_unit_if: req/gnt/rvalid data-bus bundle between load_store_unit and memory
// Master drives bus_req/bus_we/bus_addr/bus_be/bus_wdata; slave returns bus_gnt/bus_rvalid/bus_rdata.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );
  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: req/gnt/rvalid memory-access stage with load/store formatting, pipeline stall and watchdog
// Ports: clk, reset (async active-low); pipeline side lsu_read/lsu_write/funct3/address/store_data in,
// load_data/stall/misaligned/bus_error out; data bus via load_store_unit_if.master (bus).
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsu_read,
  input  logic              lsu_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       address,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              misaligned,
  output logic              bus_error,
  load_store_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  sz, sz_q, sz_d;
  logic        uns_q, uns_d, we_q, we_d, mis_q, mis_d, err_q, err_d;
  logic        mis_req, trap, tmo;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] rfmt;
  // size code 0 byte, 1 half, 2 word; funct3[2] only means unsigned for loads, so a store with it set is a word
  assign sz = ((lsu_write && funct3[2]) || funct3[1]) ? 2'd2 : {1'b0, funct3[0]};
  assign mis_req = (sz == 2'd1 && address[0]) || (sz == 2'd2 && address[1:0] != 2'b00);
  assign trap = TRAP && mis_req;
  // timeout fires in the cycle the counter would reach the limit, giving exactly TIMEOUT_CYCLES cycles per phase
  assign tmo = cnt_q + 16'd1 == 16'(TIMEOUT_CYCLES);
  assign rbyte = 8'(bus.bus_rdata >> {addr_q[1:0], 3'b000});
  assign rhalf = addr_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
  assign rfmt = sz_q == 2'd0 ? {{24{~uns_q & rbyte[7]}}, rbyte} :
                sz_q == 2'd1 ? {{16{~uns_q & rhalf[15]}}, rhalf} : bus.bus_rdata;
  assign load_data = load_data_q;
  assign misaligned = TRAP && state_q == DONE && mis_q;
  assign bus_error = state_q == DONE && err_q;
  assign bus.bus_req = state_q == REQ;
  assign bus.bus_we = bus.bus_req && we_q;
  assign bus.bus_addr = bus.bus_req ? {addr_q[31:2], 2'b00} : '0;
  assign bus.bus_be = !bus.bus_req ? 4'b0000 :
                      (!we_q || sz_q == 2'd2) ? 4'b1111 :
                      sz_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_q[1:0];
  assign bus.bus_wdata = !bus.bus_req ? '0 :
                         sz_q == 2'd0 ? {4{wdata_q[7:0]}} :
                         sz_q == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
  // the IDLE stall is combinational from the request, so it is masked while reset is asserted
  assign stall = state_q == REQ || state_q == WAIT || (state_q == IDLE && reset && (lsu_read || lsu_write));
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    sz_d = sz_q;
    uns_d = uns_q;
    we_d = we_q;
    mis_d = mis_q;
    err_d = err_q;
    load_data_d = load_data_q;
    cnt_d = '0;
    case (state_q)
      IDLE: if (lsu_read || lsu_write) begin
        addr_d = TRAP ? address : {address[31:2], sz == 2'd2 ? 2'b00 : {address[1], sz == 2'd0 && address[0]}};
        wdata_d = store_data;
        sz_d = sz;
        uns_d = funct3[2];
        we_d = lsu_write;
        mis_d = trap;
        err_d = 1'b0;
        if (trap) load_data_d = '0;
        state_d = trap ? DONE : REQ;
      end
      REQ: if (bus.bus_gnt) state_d = we_q ? DONE : WAIT;
      else if (tmo) begin
        state_d = DONE;
        err_d = 1'b1;
        load_data_d = '0;
      end else cnt_d = cnt_q + 16'd1;
      WAIT: if (bus.bus_rvalid) begin
        load_data_d = rfmt;
        state_d = DONE;
      end else if (tmo) begin
        state_d = DONE;
        err_d = 1'b1;
        load_data_d = '0;
      end else cnt_d = cnt_q + 16'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      load_data_q <= '0;
      cnt_q <= '0;
      sz_q <= '0;
      uns_q <= 1'b0;
      we_q <= 1'b0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      load_data_q <= load_data_d;
      cnt_q <= cnt_d;
      sz_q <= sz_d;
      uns_q <= uns_d;
      we_q <= we_d;
      mis_q <= mis_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for load_store_unit against a behavioural model
module tb_load_store_unit;
  localparam int TMO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef struct { logic [31:0] ld; bit mis; bit err; int st; } exp_t;
  typedef struct { bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } bexp_t;
  logic        clk, reset, lsu_read, lsu_write, stall, misaligned, bus_error;
  logic [2:0]  funct3;
  logic [31:0] address, store_data, load_data;
  logic [31:0] hold, cur_rdata;
  int          cur_gd, cur_rd, n_vec, n_err;
  bit          force_rv;
  exp_t        sb_q[$];
  bexp_t       bq[$];
  load_store_unit_if bif();
  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .lsu_read(lsu_read), .lsu_write(lsu_write), .funct3(funct3),
    .address(address), .store_data(store_data), .load_data(load_data), .stall(stall),
    .misaligned(misaligned), .bus_error(bus_error), .bus(bif)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic idle(input int n);
    lsu_read = 1'b0;
    lsu_write = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  // Model: derive the expected bus transaction and completion from access size, alignment and handshake delays
  task automatic access(input bit we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                        input int gd, input int rd, input logic [31:0] rdat);
    int sz;
    bit sgn, mis, trp, done;
    logic [31:0] ea;
    longint m, v;
    exp_t e;
    if (we) sz = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
    else sz = (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
    sgn = !we && f < 3'd4 && sz < 4;
    mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    trp = TRAP && mis;
    ea = trp ? a : (a / 32'(sz)) * 32'(sz);
    if (trp) e = '{32'd0, 1'b1, 1'b0, 1};
    else begin
      bq.push_back('{we, (ea / 32'd4) * 32'd4,
                     we ? 4'(((1 << sz) - 1) << (ea % 4)) : 4'hF,
                     sz == 1 ? (d % 256) * 32'h01010101 : sz == 2 ? (d % 65536) * 32'h00010001 : d});
      if (gd >= TMO) e = '{32'd0, 1'b0, 1'b1, 1 + TMO};
      else if (we) e = '{hold, 1'b0, 1'b0, 2 + gd};
      else if (rd >= TMO) e = '{32'd0, 1'b0, 1'b1, 2 + gd + TMO};
      else begin
        m = longint'(1) << (8 * sz);
        v = longint'({32'd0, rdat} >> (8 * (ea % 4))) % m;
        if (sgn && v >= m / 2) v -= m;
        e = '{32'(v), 1'b0, 1'b0, 3 + gd + rd};
      end
    end
    hold = e.ld;
    sb_q.push_back(e);
    cur_gd = gd;
    cur_rd = rd;
    cur_rdata = rdat;
    lsu_write = we;
    lsu_read = we ? 1'($urandom_range(0, 1)) : 1'b1;
    funct3 = f;
    address = a;
    store_data = d;
    @(posedge clk);
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      done = !stall;
    end
    if (!done) chk("done_seen", 0, 1);
  endtask
  // Bus slave: grants after cur_gd REQ cycles, returns data after cur_rd WAIT cycles, checks each new request
  initial begin
    int cnt, ph;
    bexp_t b;
    cnt = 0;
    ph = 0;
    bif.bus_gnt = 1'b0;
    bif.bus_rvalid = 1'b0;
    bif.bus_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      bif.bus_gnt = 1'b0;
      bif.bus_rvalid = force_rv;
      bif.bus_rdata = force_rv ? 32'hFFFF_FFFF : $urandom;
      if (!reset) begin
        ph = 0;
        continue;
      end
      if (ph == 2 && !stall) ph = 0;
      if (ph == 2) begin
        if (cnt == cur_rd) begin
          bif.bus_rvalid = 1'b1;
          bif.bus_rdata = cur_rdata;
          ph = 0;
        end else cnt++;
      end else if (bif.bus_req) begin
        if (ph == 0) begin
          if (bq.size() == 0) chk("unexpected_req", 1, 0);
          else begin
            b = bq.pop_front();
            chk("bus_we", bif.bus_we, b.we);
            chk("bus_addr", bif.bus_addr, b.addr);
            if (b.we) begin
              chk("bus_be", bif.bus_be, b.be);
              chk("bus_wdata", bif.bus_wdata, b.wd);
            end
          end
          ph = 1;
          cnt = 0;
        end
        if (cnt == cur_gd) begin
          bif.bus_gnt = 1'b1;
          ph = bif.bus_we ? 0 : 2;
          cnt = 0;
        end else cnt++;
      end else ph = 0;
    end
  end
  // Monitor: a stall->no-stall transition marks DONE; pop the scoreboard and compare
  initial begin
    int st;
    logic [31:0] last_ld;
    exp_t e;
    st = 0;
    last_ld = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        st = 0;
        last_ld = '0;
        chk("reset_outs", {stall, misaligned, bus_error, bif.bus_req, load_data}, 0);
        continue;
      end
      if (stall) st++;
      else if (st > 0) begin
        if (sb_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("load_data", load_data, e.ld);
          chk("misaligned", misaligned, e.mis);
          chk("bus_error", bus_error, e.err);
          chk("stall_cycles", st, e.st);
          last_ld = e.ld;
        end
        st = 0;
      end else chk("idle_outs", {misaligned, bus_error, bif.bus_req, load_data}, {3'b000, last_ld});
    end
  end
  initial begin
    n_vec = 0;
    n_err = 0;
    hold = '0;
    reset = 1'b0;
    lsu_read = 1'b0;
    lsu_write = 1'b0;
    funct3 = '0;
    address = '0;
    store_data = '0;
    force_rv = 1'b0;
    cur_gd = 0;
    cur_rd = 0;
    cur_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    access(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h0);
    idle(1);
    access(1'b0, 3'b000, 32'h102, 32'h0, 0, 2, 32'h12F45678);
    access(1'b0, 3'b100, 32'h102, 32'h0, 0, 2, 32'h12F45678);
    access(1'b0, 3'b001, 32'h101, 32'h0, 1, 1, 32'hCAFEBABE);
    access(1'b0, 3'b010, 32'h200, 32'h0, 10, 0, 32'h0);
    access(1'b1, 3'b010, 32'h204, 32'h11223344, 0, 0, 32'h0);
    access(1'b0, 3'b010, 32'h208, 32'h0, 1, 10, 32'h0);
    idle(2);
    bq.push_back('{1'b0, 32'h300, 4'hF, 32'h0});
    cur_gd = 0;
    cur_rd = 20;
    lsu_read = 1'b1;
    lsu_write = 1'b0;
    funct3 = 3'b010;
    address = 32'h300;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hold = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    lsu_read = 1'b0;
    @(negedge clk);
    force_rv = 1'b1;
    @(negedge clk);
    force_rv = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 5), $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(5);
    chk("sb_empty", sb_q.size(), 0);
    chk("bus_q_empty", bq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
